// File: rtl/dsp_mac_slice.sv
// Pipelined signed MAC slice: optional pre-adder, multiplier (optionally registered),
// framed accumulator with saturate/wrap, cascade seed, term counter and published result.
module dsp_mac_slice #(
    parameter int A_WIDTH   = 18,
    parameter int B_WIDTH   = 18,
    parameter int ACC_WIDTH = 48,
    parameter int MREG      = 1,
    parameter int SATURATE  = 1,
    parameter int CNT_WIDTH = 16
) (
    input  logic                        CLK,
    input  logic                        RSTN,
    input  logic                        CE,
    input  logic                        IN_VALID,
    input  logic                        FIRST,
    input  logic                        LAST,
    input  logic                        SUB_PRE,
    input  logic                        PRE_EN,
    input  logic                        SUB_ACC,
    input  logic                        CASC_EN,
    input  logic signed [A_WIDTH-1:0]   A,
    input  logic signed [B_WIDTH-1:0]   B,
    input  logic signed [B_WIDTH-1:0]   D,
    input  logic signed [ACC_WIDTH-1:0] PCIN,
    output logic signed [ACC_WIDTH-1:0] P,
    output logic signed [ACC_WIDTH-1:0] PCOUT,
    output logic                        OUT_VALID,
    output logic                        OVF,
    output logic [CNT_WIDTH-1:0]        CNT
);
    localparam int PRE_W  = B_WIDTH + 1;
    localparam int PROD_W = A_WIDTH + PRE_W;
    // Two guard bits so base + term can never wrap before the range test.
    localparam int SUM_W  = ((PROD_W > ACC_WIDTH) ? PROD_W : ACC_WIDTH) + 2;
    localparam logic signed [SUM_W-1:0] ACC_MAX = {{(SUM_W-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] ACC_MIN = {{(SUM_W-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}};

    typedef struct packed {
        logic first;
        logic last;
        logic sub_acc;
        logic casc_en;
    } ctl_t;

    logic                        s1_vld_q, s1_vld_d;
    logic signed [A_WIDTH-1:0]   s1_a_q, s1_a_d;
    logic signed [B_WIDTH-1:0]   s1_b_q, s1_b_d, s1_dd_q, s1_dd_d;
    logic                        s1_sub_pre_q, s1_sub_pre_d, s1_pre_en_q, s1_pre_en_d;
    ctl_t                        s1_ctl_q, s1_ctl_d;
    logic                        s2_vld_q, s2_vld_d;
    logic signed [A_WIDTH-1:0]   s2_a_q, s2_a_d;
    logic signed [PRE_W-1:0]     s2_pre_q, s2_pre_d;
    ctl_t                        s2_ctl_q, s2_ctl_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                        run_ovf_q, run_ovf_d;
    logic [CNT_WIDTH-1:0]        run_cnt_q, run_cnt_d;
    logic                        pub_q, pub_d;
    logic signed [ACC_WIDTH-1:0] p_q, p_d;
    logic                        ovf_q, ovf_d, out_valid_q, out_valid_d;
    logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;

    logic signed [PRE_W-1:0]     b_ext, d_ext, pre_c;
    logic signed [PROD_W-1:0]    prod_c;
    logic                        m_vld;
    logic signed [PROD_W-1:0]    m_prod;
    ctl_t                        m_ctl;
    logic signed [SUM_W-1:0]     prod_ext, term, base, sum;
    logic                        ovf_c;
    logic signed [ACC_WIDTH-1:0] acc_new_c;

    assign b_ext  = {s1_b_q[B_WIDTH-1], s1_b_q};
    assign d_ext  = {s1_dd_q[B_WIDTH-1], s1_dd_q};
    assign pre_c  = s1_pre_en_q ? (s1_sub_pre_q ? d_ext - b_ext : d_ext + b_ext) : b_ext;
    assign prod_c = PROD_W'(s2_a_q) * PROD_W'(s2_pre_q);

    generate
        if (MREG != 0) begin : g_mreg
            logic                     m_vld_q, m_vld_d;
            logic signed [PROD_W-1:0] m_prod_q, m_prod_d;
            ctl_t                     m_ctl_q, m_ctl_d;

            always_comb begin
                m_vld_d  = m_vld_q;
                m_prod_d = m_prod_q;
                m_ctl_d  = m_ctl_q;
                if (CE) begin
                    m_vld_d  = s2_vld_q;
                    m_prod_d = prod_c;
                    m_ctl_d  = s2_ctl_q;
                end
            end

            always_ff @(posedge CLK or negedge RSTN) begin
                if (!RSTN) begin
                    m_vld_q  <= 1'b0;
                    m_prod_q <= '0;
                    m_ctl_q  <= '0;
                end else begin
                    m_vld_q  <= m_vld_d;
                    m_prod_q <= m_prod_d;
                    m_ctl_q  <= m_ctl_d;
                end
            end

            assign m_vld  = m_vld_q;
            assign m_prod = m_prod_q;
            assign m_ctl  = m_ctl_q;
        end else begin : g_comb
            assign m_vld  = s2_vld_q;
            assign m_prod = prod_c;
            assign m_ctl  = s2_ctl_q;
        end
    endgenerate

    always_comb begin
        prod_ext = SUM_W'(m_prod);
        term     = m_ctl.sub_acc ? -prod_ext : prod_ext;
        base     = SUM_W'(acc_q);
        if (m_ctl.first) begin
            if (m_ctl.casc_en) base = SUM_W'(PCIN);
            else               base = '0;
        end
        sum       = base + term;
        ovf_c     = (sum > ACC_MAX) || (sum < ACC_MIN);
        acc_new_c = sum[ACC_WIDTH-1:0];
        if (ovf_c && (SATURATE != 0))
            acc_new_c = sum[SUM_W-1] ? ACC_MIN[ACC_WIDTH-1:0] : ACC_MAX[ACC_WIDTH-1:0];
    end

    always_comb begin
        s1_vld_d = s1_vld_q;  s1_a_d = s1_a_q;  s1_b_d = s1_b_q;  s1_dd_d = s1_dd_q;
        s1_sub_pre_d = s1_sub_pre_q;  s1_pre_en_d = s1_pre_en_q;  s1_ctl_d = s1_ctl_q;
        s2_vld_d = s2_vld_q;  s2_a_d = s2_a_q;  s2_pre_d = s2_pre_q;  s2_ctl_d = s2_ctl_q;
        acc_d = acc_q;  run_ovf_d = run_ovf_q;  run_cnt_d = run_cnt_q;  pub_d = pub_q;
        p_d = p_q;  ovf_d = ovf_q;  cnt_d = cnt_q;
        out_valid_d = 1'b0;
        if (CE) begin
            s1_vld_d     = IN_VALID;
            s1_a_d       = A;
            s1_b_d       = B;
            s1_dd_d      = D;
            s1_sub_pre_d = SUB_PRE;
            s1_pre_en_d  = PRE_EN;
            s1_ctl_d     = '{first: FIRST, last: LAST, sub_acc: SUB_ACC, casc_en: CASC_EN};
            s2_vld_d     = s1_vld_q;
            s2_a_d       = s1_a_q;
            s2_pre_d     = pre_c;
            s2_ctl_d     = s1_ctl_q;
            if (m_vld) begin
                acc_d     = acc_new_c;
                run_ovf_d = m_ctl.first ? ovf_c : (run_ovf_q | ovf_c);
                if (m_ctl.first)     run_cnt_d = CNT_WIDTH'(1);
                else if (!(&run_cnt_q)) run_cnt_d = run_cnt_q + CNT_WIDTH'(1);
            end
            pub_d = m_vld & m_ctl.last;
            // Publish stage reads the accumulator one enabled edge after the LAST beat lands.
            if (pub_q) begin
                p_d         = acc_q;
                ovf_d       = run_ovf_q;
                cnt_d       = run_cnt_q;
                out_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            s1_vld_q <= 1'b0;  s1_a_q <= '0;  s1_b_q <= '0;  s1_dd_q <= '0;
            s1_sub_pre_q <= 1'b0;  s1_pre_en_q <= 1'b0;  s1_ctl_q <= '0;
            s2_vld_q <= 1'b0;  s2_a_q <= '0;  s2_pre_q <= '0;  s2_ctl_q <= '0;
            acc_q <= '0;  run_ovf_q <= 1'b0;  run_cnt_q <= '0;  pub_q <= 1'b0;
            p_q <= '0;  ovf_q <= 1'b0;  cnt_q <= '0;  out_valid_q <= 1'b0;
        end else begin
            s1_vld_q <= s1_vld_d;  s1_a_q <= s1_a_d;  s1_b_q <= s1_b_d;  s1_dd_q <= s1_dd_d;
            s1_sub_pre_q <= s1_sub_pre_d;  s1_pre_en_q <= s1_pre_en_d;  s1_ctl_q <= s1_ctl_d;
            s2_vld_q <= s2_vld_d;  s2_a_q <= s2_a_d;  s2_pre_q <= s2_pre_d;  s2_ctl_q <= s2_ctl_d;
            acc_q <= acc_d;  run_ovf_q <= run_ovf_d;  run_cnt_q <= run_cnt_d;  pub_q <= pub_d;
            p_q <= p_d;  ovf_q <= ovf_d;  cnt_q <= cnt_d;  out_valid_q <= out_valid_d;
        end
    end

    assign P         = p_q;
    assign PCOUT     = p_q;
    assign OVF       = ovf_q;
    assign CNT       = cnt_q;
    assign OUT_VALID = out_valid_q;
endmodule

// File: tb/tb_dsp_mac_slice.sv
// Randomized and directed bench for dsp_mac_slice: three configurations share one
// stimulus stream and are compared against an arithmetic frame model.
module tb_dsp_mac_slice;
    localparam int NI = 3;
    localparam int ACCW [NI] = '{48, 20, 20};
    localparam int OPW  [NI] = '{18, 10, 10};
    localparam int SATV [NI] = '{1, 1, 0};
    localparam int CNTW [NI] = '{16, 16, 3};
    localparam int LAT  [NI] = '{4, 4, 3};

    typedef struct {
        longint p;
        longint ovf;
        longint cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rstn, ce, in_valid, first, last, sub_pre, pre_en, sub_acc, casc_en;
    logic signed [17:0] a, b, d;
    logic signed [47:0] pcin;

    logic signed [47:0] p0, pc0;
    logic               ov0, f0;
    logic [15:0]        c0;
    logic signed [19:0] p1, pc1;
    logic               ov1, f1;
    logic [15:0]        c1;
    logic signed [19:0] p2, pc2;
    logic               ov2, f2;
    logic [2:0]         c2;

    int     vec_cnt = 0;
    int     err_cnt = 0;
    longint cyc = 0;
    longint acc_cyc = 0;
    longint ov_cyc [NI];
    int     pulses [NI];
    longint m_acc [NI];
    longint m_ovf [NI];
    longint m_cnt [NI];
    longint last_p [NI];
    exp_t   exp_q [NI][$];

    always #5 clk = ~clk;

    dsp_mac_slice u_def (
        .CLK(clk), .RSTN(rstn), .CE(ce), .IN_VALID(in_valid), .FIRST(first), .LAST(last),
        .SUB_PRE(sub_pre), .PRE_EN(pre_en), .SUB_ACC(sub_acc), .CASC_EN(casc_en),
        .A(a), .B(b), .D(d), .PCIN(pcin),
        .P(p0), .PCOUT(pc0), .OUT_VALID(ov0), .OVF(f0), .CNT(c0)
    );

    dsp_mac_slice #(.A_WIDTH(10), .B_WIDTH(10), .ACC_WIDTH(20), .MREG(1), .SATURATE(1), .CNT_WIDTH(16)) u_sat (
        .CLK(clk), .RSTN(rstn), .CE(ce), .IN_VALID(in_valid), .FIRST(first), .LAST(last),
        .SUB_PRE(sub_pre), .PRE_EN(pre_en), .SUB_ACC(sub_acc), .CASC_EN(casc_en),
        .A(a[9:0]), .B(b[9:0]), .D(d[9:0]), .PCIN(pcin[19:0]),
        .P(p1), .PCOUT(pc1), .OUT_VALID(ov1), .OVF(f1), .CNT(c1)
    );

    dsp_mac_slice #(.A_WIDTH(10), .B_WIDTH(10), .ACC_WIDTH(20), .MREG(0), .SATURATE(0), .CNT_WIDTH(3)) u_wrap (
        .CLK(clk), .RSTN(rstn), .CE(ce), .IN_VALID(in_valid), .FIRST(first), .LAST(last),
        .SUB_PRE(sub_pre), .PRE_EN(pre_en), .SUB_ACC(sub_acc), .CASC_EN(casc_en),
        .A(a[9:0]), .B(b[9:0]), .D(d[9:0]), .PCIN(pcin[19:0]),
        .P(p2), .PCOUT(pc2), .OUT_VALID(ov2), .OVF(f2), .CNT(c2)
    );

    task automatic check_val(input string tag, input longint got, input longint exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic longint sx(input longint v, input int w);
        longint m, r;
        m = longint'(1) <<< w;
        r = v & (m - 1);
        if (r >= (m >>> 1)) r = r - m;
        return r;
    endfunction

    task automatic get_obs(input int i, output longint p, output longint pc, output longint v,
                           output longint f, output longint c);
        case (i)
            0:       begin p = longint'(p0); pc = longint'(pc0); v = longint'(ov0); f = longint'(f0); c = longint'(c0); end
            1:       begin p = longint'(p1); pc = longint'(pc1); v = longint'(ov1); f = longint'(f1); c = longint'(c1); end
            default: begin p = longint'(p2); pc = longint'(pc2); v = longint'(ov2); f = longint'(f2); c = longint'(c2); end
        endcase
    endtask

    task automatic clear_model();
        for (int i = 0; i < NI; i++) begin
            m_acc[i] = 0; m_ovf[i] = 0; m_cnt[i] = 0; last_p[i] = 0;
            exp_q[i].delete();
        end
    endtask

    // Frame arithmetic straight from the rules: pre-add, multiply, add or subtract,
    // range test against the signed accumulator limits, clamp or wrap.
    task automatic model_beat();
        for (int i = 0; i < NI; i++) begin
            longint av, bv, dv, pre, prod, term, base, nv, hi, lo, o;
            av = sx(longint'(a), OPW[i]);
            bv = sx(longint'(b), OPW[i]);
            dv = sx(longint'(d), OPW[i]);
            pre = pre_en ? (sub_pre ? dv - bv : dv + bv) : bv;
            prod = av * pre;
            term = sub_acc ? -prod : prod;
            base = first ? (casc_en ? sx(longint'(pcin), ACCW[i]) : 0) : m_acc[i];
            nv = base + term;
            hi = (longint'(1) <<< (ACCW[i] - 1)) - 1;
            lo = -hi - 1;
            o = (nv > hi || nv < lo) ? 1 : 0;
            if (o != 0) nv = (SATV[i] != 0) ? ((nv > hi) ? hi : lo) : sx(nv, ACCW[i]);
            m_acc[i] = nv;
            if (first) begin
                m_ovf[i] = o;
                m_cnt[i] = 1;
            end else begin
                m_ovf[i] = m_ovf[i] | o;
                if (m_cnt[i] < (longint'(1) <<< CNTW[i]) - 1) m_cnt[i]++;
            end
            if (last) exp_q[i].push_back('{nv, m_ovf[i], m_cnt[i]});
        end
    endtask

    task automatic check_outputs(input bit ce_s);
        longint p, pc, v, f, c;
        exp_t e;
        for (int i = 0; i < NI; i++) begin
            get_obs(i, p, pc, v, f, c);
            if (v != 0) begin
                pulses[i]++;
                ov_cyc[i] = cyc;
                if (!ce_s) check_val($sformatf("u%0d_valid_while_ce0", i), v, 0);
                if (exp_q[i].size() == 0) begin
                    check_val($sformatf("u%0d_unexpected_valid", i), v, 0);
                end else begin
                    e = exp_q[i].pop_front();
                    check_val($sformatf("u%0d_p", i), p, e.p);
                    check_val($sformatf("u%0d_pcout", i), pc, e.p);
                    check_val($sformatf("u%0d_ovf", i), f, e.ovf);
                    check_val($sformatf("u%0d_cnt", i), c, e.cnt);
                    last_p[i] = e.p;
                end
            end else begin
                check_val($sformatf("u%0d_p_hold", i), p, last_p[i]);
            end
        end
    endtask

    task automatic tick();
        bit ce_s;
        @(posedge clk);
        cyc++;
        ce_s = ce;
        if (!rstn) clear_model();
        else if (ce && in_valid) begin
            model_beat();
            acc_cyc = cyc;
        end
        @(negedge clk);
        if (rstn) check_outputs(ce_s);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic drive(input bit f, input bit l, input bit pe, input bit sp, input bit sa,
                         input bit cs, input longint av, input longint bv, input longint dv);
        in_valid = 1'b1; first = f; last = l; pre_en = pe; sub_pre = sp; sub_acc = sa; casc_en = cs;
        a = 18'(av); b = 18'(bv); d = 18'(dv);
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        longint p, pc, v, f, c;
        for (int i = 0; i < NI; i++) begin
            get_obs(i, p, pc, v, f, c);
            check_val($sformatf("%s_u%0d_p", tag, i), p, 0);
            check_val($sformatf("%s_u%0d_pcout", tag, i), pc, 0);
            check_val($sformatf("%s_u%0d_ovf", tag, i), f, 0);
            check_val($sformatf("%s_u%0d_cnt", tag, i), c, 0);
            check_val($sformatf("%s_u%0d_valid", tag, i), v, 0);
        end
    endtask

    task automatic check_p(input string tag, input int i, input longint ep, input longint eo, input longint ec);
        longint p, pc, v, f, c;
        get_obs(i, p, pc, v, f, c);
        check_val($sformatf("%s_u%0d_p", tag, i), p, ep);
        check_val($sformatf("%s_u%0d_ovf", tag, i), f, eo);
        check_val($sformatf("%s_u%0d_cnt", tag, i), c, ec);
    endtask

    initial begin
        int     snap [NI];
        longint beat_cyc;
        rstn = 1'b0; ce = 1'b1; in_valid = 1'b0; first = 1'b0; last = 1'b0;
        sub_pre = 1'b0; pre_en = 1'b0; sub_acc = 1'b0; casc_en = 1'b0;
        a = '0; b = '0; d = '0; pcin = '0;
        for (int i = 0; i < NI; i++) begin pulses[i] = 0; ov_cyc[i] = 0; end
        repeat (2) tick();
        check_all_zero("reset");
        rstn = 1'b1;
        idle(2);

        // Single-term frame through the pre-adder: 3*(5+4)=27, latency 3+MREG.
        for (int i = 0; i < NI; i++) snap[i] = pulses[i];
        drive(1, 1, 1, 0, 0, 0, 3, 4, 5);
        beat_cyc = acc_cyc;
        idle(7);
        for (int i = 0; i < NI; i++) begin
            check_p("t1", i, 27, 0, 1);
            check_val($sformatf("t1_u%0d_latency", i), ov_cyc[i] - beat_cyc, LAT[i]);
            check_val($sformatf("t1_u%0d_pulses", i), pulses[i] - snap[i], 1);
        end

        // Four back-to-back beats, third subtracted.
        drive(1, 0, 0, 0, 0, 0, 2, 10, 0);
        drive(0, 0, 0, 0, 0, 0, 2, 20, 0);
        drive(0, 0, 0, 0, 1, 0, 2, 30, 0);
        drive(0, 1, 0, 0, 0, 0, 2, 40, 0);
        beat_cyc = acc_cyc;
        idle(7);
        for (int i = 0; i < NI; i++) begin
            check_p("t2", i, 80, 0, 4);
            check_val($sformatf("t2_u%0d_latency", i), ov_cyc[i] - beat_cyc, LAT[i]);
        end

        // 3 x 511*511 overflows a 20-bit accumulator: clamp vs wrap.
        drive(1, 0, 0, 0, 0, 0, 511, 511, 0);
        drive(0, 0, 0, 0, 0, 0, 511, 511, 0);
        drive(0, 1, 0, 0, 0, 0, 511, 511, 0);
        idle(7);
        check_p("t3", 0, 783363, 0, 3);
        check_p("t3", 1, 524287, 1, 3);
        check_p("t3", 2, -265213, 1, 3);
        drive(1, 1, 0, 0, 0, 0, 1, 1, 0);
        idle(7);
        for (int i = 0; i < NI; i++) check_p("t3b", i, 1, 0, 1);

        // Cascade seed with a 3-cycle CE stall in flight.
        pcin = 48'sd1000;
        for (int i = 0; i < NI; i++) snap[i] = pulses[i];
        drive(1, 1, 0, 0, 0, 1, -5, 6, 0);
        beat_cyc = acc_cyc;
        idle(1);
        ce = 1'b0;
        idle(3);
        ce = 1'b1;
        idle(8);
        for (int i = 0; i < NI; i++) begin
            check_p("t5", i, 970, 0, 1);
            check_val($sformatf("t5_u%0d_latency", i), ov_cyc[i] - beat_cyc, LAT[i] + 3);
            check_val($sformatf("t5_u%0d_pulses", i), pulses[i] - snap[i], 1);
        end
        pcin = '0;

        // Reset mid-frame: partial sum discarded, continuation starts from zero.
        drive(1, 0, 0, 0, 0, 0, 1, 100, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 200, 0);
        in_valid = 1'b0;
        #2 rstn = 1'b0;
        #1 check_all_zero("t6_async");
        tick();
        rstn = 1'b1;
        for (int i = 0; i < NI; i++) snap[i] = pulses[i];
        idle(7);
        for (int i = 0; i < NI; i++)
            check_val($sformatf("t6_u%0d_no_pulse", i), pulses[i] - snap[i], 0);
        drive(0, 0, 0, 0, 0, 0, 1, 300, 0);
        drive(0, 1, 0, 0, 0, 0, 1, 400, 0);
        idle(7);
        for (int i = 0; i < NI; i++) check_p("t6", i, 700, 0, 2);
        drive(1, 1, 0, 0, 0, 0, 1, 1, 0);
        idle(7);
        for (int i = 0; i < NI; i++) check_p("t6b", i, 1, 0, 1);

        // Randomized bursts: bubbles, CE gaps, arbitrary framing; PCIN constant per burst.
        for (int burst = 0; burst < 20; burst++) begin
            if (burst % 3 == 0) pcin = 48'({$urandom, $urandom});
            else                pcin = 48'($urandom_range(0, 4000)) - 48'sd2000;
            for (int n = 0; n < 30; n++) begin
                ce       = ($urandom_range(0, 4) != 0);
                in_valid = ($urandom_range(0, 3) != 0);
                first    = ($urandom_range(0, 5) == 0);
                last     = ($urandom_range(0, 4) == 0);
                sub_pre  = 1'($urandom_range(0, 1));
                pre_en   = 1'($urandom_range(0, 1));
                sub_acc  = 1'($urandom_range(0, 1));
                casc_en  = 1'($urandom_range(0, 1));
                a = 18'($urandom);
                b = 18'($urandom);
                d = 18'($urandom);
                tick();
            end
            ce = 1'b1;
            idle(8);
        end

        for (int i = 0; i < NI; i++)
            check_val($sformatf("u%0d_results_outstanding", i), longint'(exp_q[i].size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
